// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and result slot feeding an external combinational 8-bit alu.
// Optional accumulator operand path is enabled with `define ALU_CMD_ACC_EN.
//
// state  | meaning
// S_IDLE | result slot empty; capture the FIFO head as soon as one is queued
// S_HOLD | result slot full; wait for res_ready, refilling back-to-back if possible
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_sel,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
`ifdef ALU_CMD_ACC_EN
    input  logic                     in_use_acc,
`endif
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [3:0]               alu_sel,
    input  logic [7:0]               alu_out,
    input  logic                     alu_c,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
    output logic                     res_carry,
    output logic [3:0]               res_sel,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [0:0] {S_IDLE, S_HOLD} state_t;

    state_t        state;
    logic [3:0]    mem_sel [DEPTH];
    logic [7:0]    mem_a   [DEPTH];
    logic [7:0]    mem_b   [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready = rst_n && (count < CNT_FULL);
    assign push     = in_valid && in_ready;
    // Issue only from the registered count: a command written this edge is never bypassed.
    assign pop      = (count != '0) && ((state == S_IDLE) || res_ready);

    assign alu_b   = mem_b[rd_ptr];
    assign alu_sel = mem_sel[rd_ptr];

`ifdef ALU_CMD_ACC_EN
    logic       mem_acc [DEPTH];
    logic [7:0] acc;

    assign alu_a = mem_acc[rd_ptr] ? acc : mem_a[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (pop) begin
            acc <= alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_acc[wr_ptr] <= in_use_acc;
        end
    end
`else
    assign alu_a = mem_a[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_sel[wr_ptr] <= in_sel;
                mem_a[wr_ptr]   <= in_a;
                mem_b[wr_ptr]   <= in_b;
                wr_ptr          <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_sel   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        res_data  <= alu_out;
                        res_carry <= (alu_sel == 4'b0000) && alu_c;
                        res_sel   <= alu_sel;
                        res_valid <= 1'b1;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (pop) begin
                        res_data  <= alu_out;
                        res_carry <= (alu_sel == 4'b0000) && alu_c;
                        res_sel   <= alu_sel;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural alu model; expected results are queued
// as commands are accepted and compared as the result slot hands them over.
module tb_alu_cmd_sequencer;

    typedef logic [12:0] res_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_sel;
    logic [7:0] in_a;
    logic [7:0] in_b;
`ifdef ALU_CMD_ACC_EN
    logic       in_use_acc;
`endif
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_c;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic [3:0] res_sel;
    logic [2:0] count;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_a(in_a), .in_b(in_b),
`ifdef ALU_CMD_ACC_EN
        .in_use_acc(in_use_acc),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_sel(res_sel),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Carry out is raised for every non-add op so masking is exercised.
    function automatic logic [8:0] alu_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (s)
            4'b0000: r = {1'b0, a} + {1'b0, b};
            4'b0001: r = {1'b1, a - b};
            4'b1110: r = {1'b1, a & b};
            4'b1111: r = {1'b1, 7'b0, (a == b)};
            default: r = {1'b1, a ^ b};
        endcase
        return r;
    endfunction

    always_comb {alu_c, alu_out} = alu_f(alu_sel, alu_a, alu_b);

    function automatic res_t expect_of(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        r = alu_f(s, a, b);
        return {r[7:0], (s == 4'b0000) & r[8], s};
    endfunction

    // Called just after a falling edge with inputs set; advances to the next falling edge.
    task automatic tick(output logic took, output res_t act);
        #1;
        took = res_valid && res_ready;
        act  = {res_data, res_carry, res_sel};
        if (in_valid && in_ready) exp_q.push_back(expect_of(in_sel, in_a, in_b));
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_checks++; if ({res_data, res_carry, res_sel} !== 13'h0) begin n_fail++; $display("FAIL reset_res got %h want 0", {res_data, res_carry, res_sel}); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low got %b want 0", in_ready); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_release got %b want 1", in_ready); end
    endtask

    task automatic test_single_add();
        in_sel = 4'b0000; in_a = 8'hF0; in_b = 8'hCE; in_valid = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency_early got %b want 0", res_valid); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL add_count got %0d want 1", count); end
        @(negedge clk);
        #1;
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL add_res_valid got %b want 1", res_valid); end
        n_checks++; if ({res_data, res_carry, res_sel} !== {8'hBE, 1'b1, 4'h0}) begin n_fail++; $display("FAIL add_result got %h want %h", {res_data, res_carry, res_sel}, {8'hBE, 1'b1, 4'h0}); end
        @(negedge clk);
        #1;
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_slot_empty got %b want 0", res_valid); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic       took;
        res_t       act;
        res_t       exp;
        logic [3:0] sels [5] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0};
        int         got = 0;
        int         first = -1;
        int         last = -1;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_sel = sels[i]; in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'b1;
            tick(took, act);
        end
        in_sel = 4'h3; in_a = 8'h11; in_b = 8'h22;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_count got %0d want 4", count); end
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held got %b want 1", res_valid); end
        in_valid = 1'b0; res_ready = 1'b1;
        for (int t = 0; t < 12 && exp_q.size() != 0; t++) begin
            tick(took, act);
            if (took) begin
                exp = exp_q.pop_front();
                got++;
                if (first < 0) first = t;
                last = t;
                n_checks++; if (act !== exp) begin n_fail++; $display("FAIL bp_result got %h want %h", act, exp); end
            end
        end
        n_checks++; if (got !== 5) begin n_fail++; $display("FAIL bp_result_count got %0d want 5", got); end
        n_checks++; if (first !== 0 || last !== 4) begin n_fail++; $display("FAIL bp_throughput got first %0d last %0d want 0 4", first, last); end
        exp_q.delete();
    endtask

    task automatic test_logic_ops();
        logic took;
        res_t act;
        logic [3:0] s [3] = '{4'b1110, 4'b1111, 4'b0001};
        logic [7:0] a [3] = '{8'h05, 8'h3C, 8'h03};
        logic [7:0] b [3] = '{8'h03, 8'h3C, 8'h05};
        res_t       lit [3] = '{{8'h01, 1'b0, 4'hE}, {8'h01, 1'b0, 4'hF}, {8'hFE, 1'b0, 4'h1}};
        int         k = 0;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_sel = s[i]; in_a = a[i]; in_b = b[i]; in_valid = 1'b1;
            tick(took, act);
            if (took && k < 3) begin
                n_checks++; if (act !== lit[k]) begin n_fail++; $display("FAIL logic_result%0d got %h want %h", k, act, lit[k]); end
                k++;
            end
        end
        in_valid = 1'b0;
        for (int t = 0; t < 8 && k < 3; t++) begin
            tick(took, act);
            if (took) begin
                n_checks++; if (act !== lit[k]) begin n_fail++; $display("FAIL logic_result%0d got %h want %h", k, act, lit[k]); end
                k++;
            end
        end
        n_checks++; if (k !== 3) begin n_fail++; $display("FAIL logic_result_count got %0d want 3", k); end
        repeat (2) @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic took;
        res_t act;
        res_t exp;
        int   got = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_sel = 4'h0; in_a = 8'(8'h10 + i); in_b = 8'h01; in_valid = 1'b1;
            tick(took, act);
        end
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready_low got %b want 0", in_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count got %0d want 0", count); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_res_valid got %b want 0", res_valid); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        exp_q.delete();
        in_sel = 4'h2; in_a = 8'hA5; in_b = 8'h0F; in_valid = 1'b1; res_ready = 1'b1;
        tick(took, act);
        in_valid = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick(took, act);
            if (took) begin
                got++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL rstmid_stale_result got %h want none", act);
                end else begin
                    exp = exp_q.pop_front();
                    n_checks++; if (act !== exp) begin n_fail++; $display("FAIL rstmid_result got %h want %h", act, exp); end
                end
            end
        end
        n_checks++; if (got !== 1) begin n_fail++; $display("FAIL rstmid_result_count got %0d want 1", got); end
    endtask

    task automatic test_full_pop();
        logic took;
        res_t act;
        res_t exp;
        int   got = 0;
        exp_q.delete();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_sel = 4'(i); in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'b1;
            tick(took, act);
        end
        in_sel = 4'hF; in_a = 8'h77; in_b = 8'h77; in_valid = 1'b1; res_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        tick(took, act);
        exp = exp_q.pop_front();
        n_checks++; if (took !== 1'b1 || act !== exp) begin n_fail++; $display("FAIL full_pop_result got %b/%h want 1/%h", took, act, exp); end
        #1;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count got %0d want 3", count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_reopen got %b want 1", in_ready); end
        tick(took, act);
        exp = exp_q.pop_front();
        n_checks++; if (took !== 1'b1 || act !== exp) begin n_fail++; $display("FAIL full_push_pop_result got %b/%h want 1/%h", took, act, exp); end
        #1;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_push_pop_count got %0d want 3", count); end
        in_valid = 1'b0;
        for (int t = 0; t < 10 && exp_q.size() != 0; t++) begin
            tick(took, act);
            if (took) begin
                exp = exp_q.pop_front();
                got++;
                n_checks++; if (act !== exp) begin n_fail++; $display("FAIL full_drain_result got %h want %h", act, exp); end
            end
        end
        n_checks++; if (got !== 4) begin n_fail++; $display("FAIL full_drain_count got %0d want 4", got); end
        repeat (2) @(negedge clk);
    endtask

`ifdef ALU_CMD_ACC_EN
    task automatic test_acc();
        logic took;
        res_t act;
        logic       ua  [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] lit [3] = '{8'h02, 8'h03, 8'h04};
        int         k = 0;
        res_ready = 1'b1;
        for (int t = 0; t < 10 && k < 3; t++) begin
            if (t < 3) begin
                in_sel = 4'h0; in_a = 8'h01; in_b = 8'h01; in_use_acc = ua[t]; in_valid = 1'b1;
                if (t > 0) in_a = 8'h55;
            end else begin
                in_valid = 1'b0; in_use_acc = 1'b0;
            end
            tick(took, act);
            if (took) begin
                n_checks++; if (act[12:5] !== lit[k]) begin n_fail++; $display("FAIL acc_result%0d got %h want %h", k, act[12:5], lit[k]); end
                k++;
            end
        end
        n_checks++; if (k !== 3) begin n_fail++; $display("FAIL acc_result_count got %0d want 3", k); end
        in_valid = 1'b0;
        exp_q.delete();
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_sel = 4'h0; in_a = 8'h00; in_b = 8'h00;
`ifdef ALU_CMD_ACC_EN
        in_use_acc = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_single_add();
        test_backpressure();
        test_logic_ops();
        test_reset_mid();
        test_full_pop();
`ifdef ALU_CMD_ACC_EN
        test_acc();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
